// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares the single unified memory port of the riscv32i core between the
// instruction-fetch unit and the load/store unit. One transaction is in
// flight at a time; responses are routed back to the owning requester and
// a transaction that stays in ISSUE+WAIT for TIMEOUT_CYC cycles is aborted
// with a bus_err pulse.
//
// Optional feature: define RISCV_ARB_RR_EN for round-robin arbitration.
// Without it the LSU has fixed priority over fetch.
//
// state | meaning
// IDLE  | no transaction; grant the winning requester combinationally
// ISSUE | mem_req high with latched fields, waiting for mem_gnt
// WAIT  | request accepted, waiting for mem_rvalid
module riscv_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);

  state_e                state_q;
  logic                  owner_q;   // 1 = load/store unit, 0 = fetch
  logic [15:0]           cnt_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [DATA_W/8-1:0]   mem_be_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;

  logic pick_ls;
  logic grant_ok;
  logic done_raw;
  logic done;
  logic tmo;

`ifdef RISCV_ARB_RR_EN
  logic rr_q;   // 1 favours the load/store unit on a tie

  assign pick_ls = ls_req && (!if_req || rr_q);
`else
  assign pick_ls = ls_req;
`endif

  // A response in ISSUE only counts when it comes with the grant.
  assign done_raw = ((state_q == ST_ISSUE) && mem_gnt && mem_rvalid) ||
                    ((state_q == ST_WAIT) && mem_rvalid);
  assign done     = done_raw && !reset;
  assign tmo      = !reset && (state_q != ST_IDLE) && (cnt_q == TMO_LIM) && !done_raw;
  assign grant_ok = !reset && (state_q == ST_IDLE) && (if_req || ls_req);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Same-cycle grants, response routing and abort signalling.
  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rdata  = '0;
    bus_err   = tmo;
    if (grant_ok) begin
      if (pick_ls) ls_gnt = 1'b1;
      else         if_gnt = 1'b1;
    end
    if (done || tmo) begin
      if (owner_q) ls_rvalid = 1'b1;
      else         if_rvalid = 1'b1;
    end
    if (done) begin
      if (owner_q) ls_rdata = mem_rdata;
      else         if_rdata = mem_rdata;
    end
  end

  // Transaction FSM with latched memory fields and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef RISCV_ARB_RR_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (if_req || ls_req) begin
            state_q   <= ST_ISSUE;
            mem_req_q <= 1'b1;
            cnt_q     <= '0;
            owner_q   <= pick_ls;
            if (pick_ls) begin
              mem_we_q    <= ls_we;
              mem_be_q    <= ls_be;
              mem_addr_q  <= ls_addr;
              mem_wdata_q <= ls_wdata;
            end else begin
              mem_we_q    <= 1'b0;
              mem_be_q    <= '1;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
            end
`ifdef RISCV_ARB_RR_EN
            rr_q <= ~rr_q;
`endif
          end
        end
        ST_ISSUE: begin
          if (done || tmo) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
            if (mem_gnt) begin
              state_q   <= ST_WAIT;
              mem_req_q <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (done || tmo) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Testbench for riscv_mem_arbiter: directed vector table, hand-written
// timeout / reset sequences and a randomized run against a transaction
// level reference model. Built with TIMEOUT_CYC = 8.
module tb_riscv_mem_arbiter;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        lr, lw;
    logic [31:0] la, lwd;
    logic        mg, mv;
    logic [31:0] mrd;
    logic        eig, elg, eirv, elrv;
    logic [31:0] erd;
    logic        emreq, emwe;
    logic [31:0] emaddr, emwd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    if_req = 0; if_addr = '0;
    ls_req = 0; ls_we = 0; ls_be = 4'hF; ls_addr = '0; ls_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic add(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                     input logic [31:0] la, input logic [31:0] lwd, input logic mg,
                     input logic mv, input logic [31:0] mrd, input logic eig, input logic elg,
                     input logic eirv, input logic elrv, input logic [31:0] erd,
                     input logic emreq, input logic emwe, input logic [31:0] emaddr,
                     input logic [31:0] emwd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.lr = lr; v.lw = lw; v.la = la; v.lwd = lwd;
    v.mg = mg; v.mv = mv; v.mrd = mrd;
    v.eig = eig; v.elg = elg; v.eirv = eirv; v.elrv = elrv; v.erd = erd;
    v.emreq = emreq; v.emwe = emwe; v.emaddr = emaddr; v.emwd = emwd;
    vq.push_back(v);
  endtask

  task automatic tmo_seq(input bit late_done);
    idle_in();
    ls_req = 1; ls_we = 0; ls_addr = 32'h300;
    #3; chk("tmo ls_gnt", ls_gnt, 1);
    step();
    ls_req = 0; mem_gnt = 1;
    #3; chk("tmo mem_req", mem_req, 1);
    step();
    mem_gnt = 0; mem_rdata = 32'hFFFF_FFFF;
    for (int k = 2; k <= TMO; k++) begin
      #3;
      chk($sformatf("tmo early rvalid c%0d", k), ls_rvalid, 0);
      chk($sformatf("tmo early bus_err c%0d", k), bus_err, 0);
      step();
    end
    mem_rvalid = late_done;
    #3;
    chk("tmo ls_rvalid", ls_rvalid, 1);
    chk("tmo bus_err", bus_err, late_done ? 1'b0 : 1'b1);
    chk("tmo ls_rdata", ls_rdata, late_done ? 32'hFFFF_FFFF : 32'h0);
    chk("tmo mem_req", mem_req, 0);
    step();
    idle_in();
    if_req = 1; if_addr = 32'h40;
    #3;
    chk("post-tmo if_gnt", if_gnt, 1);
    chk("post-tmo bus_err", bus_err, 0);
    step();
    if_req = 0; mem_gnt = 1;
    #3; chk("post-tmo mem_addr", mem_addr, 32'h40);
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234;
    #3;
    chk("post-tmo if_rvalid", if_rvalid, 1);
    chk("post-tmo if_rdata", if_rdata, 32'h1234);
    step();
    idle_in();
  endtask

  // Random-run state
  bit          ifp, lsp, lwe, win_ls, done, tmo;
  logic [31:0] ia, la, lwd;
  logic [3:0]  lbe;
  bit          m_busy, m_acc, m_own_ls, m_fav_ls, m_we;
  int          m_age;
  logic [31:0] m_addr, m_wd;
  logic [3:0]  m_be;
  bit          e_ig, e_lg, e_mreq;

  initial begin
    reset = 1;
    idle_in();
    do_reset();
    #3;
    chk("rst if_gnt", if_gnt, 0);
    chk("rst ls_gnt", ls_gnt, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_be", mem_be, 0);
    chk("rst bus_err", bus_err, 0);
    step();

`ifdef RISCV_ARB_RR_EN
    add(1, 'h20, 1, 1, 'h100, 'hDEADBEEF, 0, 0, 0,     1, 0, 0, 0, 0,     0, 0, 0, 0);
    add(0, 0,    1, 1, 'h100, 'hDEADBEEF, 1, 0, 0,     0, 0, 0, 0, 0,     1, 0, 'h20, 0);
    add(0, 0,    1, 1, 'h100, 'hDEADBEEF, 0, 1, 'h13,  0, 0, 1, 0, 'h13,  0, 0, 0, 0);
    add(1, 'h24, 1, 1, 'h100, 'hDEADBEEF, 0, 0, 0,     0, 1, 0, 0, 0,     0, 0, 0, 0);
    add(1, 'h24, 0, 0, 0, 0,              1, 0, 0,     0, 0, 0, 0, 0,     1, 1, 'h100, 'hDEADBEEF);
    add(1, 'h24, 0, 0, 0, 0,              0, 1, 0,     0, 0, 0, 1, 0,     0, 0, 0, 0);
    add(1, 'h24, 0, 0, 0, 0,              0, 0, 0,     1, 0, 0, 0, 0,     0, 0, 0, 0);
    add(0, 0,    0, 0, 0, 0,              1, 1, 'h99,  0, 0, 1, 0, 'h99,  1, 0, 'h24, 0);
`else
    add(1, 'h20, 1, 1, 'h100, 'hDEADBEEF, 0, 0, 0,     0, 1, 0, 0, 0,     0, 0, 0, 0);
    add(1, 'h20, 0, 0, 0, 0,              1, 0, 0,     0, 0, 0, 0, 0,     1, 1, 'h100, 'hDEADBEEF);
    add(1, 'h20, 0, 0, 0, 0,              0, 1, 0,     0, 0, 0, 1, 0,     0, 0, 0, 0);
    add(1, 'h20, 0, 0, 0, 0,              0, 0, 0,     1, 0, 0, 0, 0,     0, 0, 0, 0);
    add(0, 0,    0, 0, 0, 0,              1, 0, 0,     0, 0, 0, 0, 0,     1, 0, 'h20, 0);
    add(0, 0,    0, 0, 0, 0,              0, 1, 'h13,  0, 0, 1, 0, 'h13,  0, 0, 0, 0);
`endif
    // single fetch, then a stray memory handshake in IDLE
    add(1, 'h10, 0, 0, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0,            0, 0, 0, 0);
    add(0, 0,    0, 0, 0, 0, 1, 0, 0,            0, 0, 0, 0, 0,            1, 0, 'h10, 0);
    add(0, 0,    0, 0, 0, 0, 0, 1, 'h513,        0, 0, 1, 0, 'h513,        0, 0, 0, 0);
    add(0, 0,    0, 0, 0, 0, 1, 1, 'hFFFF,       0, 0, 0, 0, 0,            0, 0, 0, 0);
    // zero-latency memory, back-to-back loads
    add(0, 0,    1, 0, 'h200, 0, 0, 0, 0,        0, 1, 0, 0, 0,            0, 0, 0, 0);
    add(0, 0,    0, 0, 0, 0, 1, 1, 'hCAFE0001,   0, 0, 0, 1, 'hCAFE0001,   1, 0, 'h200, 0);
    add(0, 0,    1, 0, 'h204, 0, 0, 0, 0,        0, 1, 0, 0, 0,            0, 0, 0, 0);
    add(0, 0,    0, 0, 0, 0, 1, 0, 0,            0, 0, 0, 0, 0,            1, 0, 'h204, 0);
    add(0, 0,    0, 0, 0, 0, 0, 1, 'h55,         0, 0, 0, 1, 'h55,         0, 0, 0, 0);
    add(0, 0,    0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0, 0);

    foreach (vq[i]) begin
      if_req = vq[i].ir; if_addr = vq[i].ia;
      ls_req = vq[i].lr; ls_we = vq[i].lw; ls_be = 4'hF;
      ls_addr = vq[i].la; ls_wdata = vq[i].lwd;
      mem_gnt = vq[i].mg; mem_rvalid = vq[i].mv; mem_rdata = vq[i].mrd;
      #3;
      chk($sformatf("vec%0d if_gnt", i), if_gnt, vq[i].eig);
      chk($sformatf("vec%0d ls_gnt", i), ls_gnt, vq[i].elg);
      chk($sformatf("vec%0d if_rvalid", i), if_rvalid, vq[i].eirv);
      chk($sformatf("vec%0d ls_rvalid", i), ls_rvalid, vq[i].elrv);
      chk($sformatf("vec%0d mem_req", i), mem_req, vq[i].emreq);
      chk($sformatf("vec%0d bus_err", i), bus_err, 0);
      if (vq[i].eirv) begin
        chk($sformatf("vec%0d if_rdata", i), if_rdata, vq[i].erd);
        chk($sformatf("vec%0d ls_rdata idle", i), ls_rdata, 0);
      end
      if (vq[i].elrv) begin
        chk($sformatf("vec%0d ls_rdata", i), ls_rdata, vq[i].erd);
        chk($sformatf("vec%0d if_rdata idle", i), if_rdata, 0);
      end
      if (vq[i].emreq) begin
        chk($sformatf("vec%0d mem_addr", i), mem_addr, vq[i].emaddr);
        chk($sformatf("vec%0d mem_we", i), mem_we, vq[i].emwe);
        chk($sformatf("vec%0d mem_be", i), mem_be, 4'hF);
        if (vq[i].emwe) chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vq[i].emwd);
      end
      step();
    end
    idle_in();

    tmo_seq(0);
    tmo_seq(1);

    // reset while waiting for a response
    idle_in();
    if_req = 1; if_addr = 32'h50;
    #3; chk("rstw if_gnt", if_gnt, 1);
    step();
    if_req = 0; mem_gnt = 1;
    step();
    mem_gnt = 0; reset = 1;
    #3; chk("rstw rvalid in reset", if_rvalid, 0);
    step();
    reset = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    #3;
    chk("rstw late if_rvalid", if_rvalid, 0);
    chk("rstw late ls_rvalid", ls_rvalid, 0);
    chk("rstw bus_err", bus_err, 0);
    chk("rstw mem_req", mem_req, 0);
    chk("rstw mem_addr", mem_addr, 0);
    chk("rstw if_rdata", if_rdata, 0);
    step();
    idle_in();
    if_req = 1; if_addr = 32'h60;
    #3; chk("rstw fresh if_gnt", if_gnt, 1);
    step();
    if_req = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h88;
    #3;
    chk("rstw fresh mem_addr", mem_addr, 32'h60);
    chk("rstw fresh if_rvalid", if_rvalid, 1);
    chk("rstw fresh if_rdata", if_rdata, 32'h88);
    step();

    // randomized run against a transaction-level model
    do_reset();
    ifp = 0; lsp = 0; m_busy = 0; m_acc = 0; m_age = 0;
    ia = '0; la = '0; lwd = '0; lwe = 0; lbe = 4'hF;
`ifdef RISCV_ARB_RR_EN
    m_fav_ls = 0;
`else
    m_fav_ls = 1;
`endif
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!ifp) begin
        if ($urandom_range(0, 2) == 0) begin ifp = 1; ia = $urandom; end
      end else if ($urandom_range(0, 15) == 0) ifp = 0;
      if (!lsp) begin
        if ($urandom_range(0, 2) == 0) begin
          lsp = 1; la = $urandom; lwe = 1'($urandom_range(0, 1));
          lbe = 4'($urandom); lwd = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) lsp = 0;
      if_req = ifp; if_addr = ia;
      ls_req = lsp; ls_we = lwe; ls_be = lbe; ls_addr = la; ls_wdata = lwd;
      mem_gnt = 1'($urandom_range(0, 1));
      mem_rvalid = ($urandom_range(0, 9) < 3);
      mem_rdata = $urandom;
      #3;
      e_ig = 0; e_lg = 0; done = 0; tmo = 0;
      e_mreq = m_busy && !m_acc;
      if (!m_busy) begin
        if (ifp || lsp) begin
          win_ls = lsp && (!ifp || m_fav_ls);
          e_ig = !win_ls;
          e_lg = win_ls;
        end
      end else begin
        done = mem_rvalid && (m_acc || mem_gnt);
        tmo  = !done && (m_age == TMO);
      end
      chk("rnd if_gnt", if_gnt, e_ig);
      chk("rnd ls_gnt", ls_gnt, e_lg);
      chk("rnd mem_req", mem_req, e_mreq);
      chk("rnd if_rvalid", if_rvalid, (done || tmo) && !m_own_ls);
      chk("rnd ls_rvalid", ls_rvalid, (done || tmo) && m_own_ls);
      chk("rnd bus_err", bus_err, tmo);
      if (e_mreq) begin
        chk("rnd mem_addr", mem_addr, m_addr);
        chk("rnd mem_we", mem_we, m_we);
        chk("rnd mem_be", mem_be, m_be);
        if (m_we) chk("rnd mem_wdata", mem_wdata, m_wd);
      end
      if ((done || tmo) && !m_own_ls) begin
        chk("rnd if_rdata", if_rdata, tmo ? 32'h0 : mem_rdata);
        chk("rnd ls_rdata nonowner", ls_rdata, 0);
      end
      if ((done || tmo) && m_own_ls) begin
        if (tmo || !m_we) chk("rnd ls_rdata", ls_rdata, tmo ? 32'h0 : mem_rdata);
        chk("rnd if_rdata nonowner", if_rdata, 0);
      end
      if (!m_busy) begin
        if (e_ig || e_lg) begin
          m_busy = 1; m_acc = 0; m_age = 0; m_own_ls = e_lg;
          m_addr = e_lg ? la : ia;
          m_we   = e_lg ? lwe : 1'b0;
          m_be   = e_lg ? lbe : 4'hF;
          m_wd   = lwd;
`ifdef RISCV_ARB_RR_EN
          m_fav_ls = !m_fav_ls;
`endif
        end
      end else if (done || tmo) begin
        m_busy = 0;
      end else begin
        m_age++;
        if (mem_gnt) m_acc = 1;
      end
      if (e_ig) ifp = 0;
      if (e_lg) lsp = 0;
      step();
    end
    idle_in();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
